// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if -- operand/result bundle between the execute stage and the
// iterative multiply/divide unit.
//   start : decoder flags the current instruction as an MDU op
//   op    : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no effect
//   a, b  : rs / rt operand buses
//   hi/lo : HI/LO registers, read by MFHI/MFLO in write-back
//   busy  : unit is not idle
//   done  : one-cycle pulse, results are final
//   stall : freezes PC and register-file writes
// master: execute-stage side (drives start/op/a/b)
// slave : the MDU itself
interface mdu_hilo_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  modport master (
    output start, op, a, b,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, a, b,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo -- iterative multiply/divide unit with HI/LO register pair.
// Executes MULT, MULTU, DIV, DIVU (one iteration per cycle, 32 iterations)
// and MTHI/MTLO (single edge, no stall).
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mdu_hilo_if.slave (start, op, a, b in; hi, lo, busy, done, stall out)
// Parameter ITER (32) is tied to the data width and must not be overridden.
// Optional build macro MDU_ZERO_SKIP_EN: a zero multiply operand or a zero
// divisor jumps straight from IDLE to FIN, giving a 2-cycle stall.
module mdu_hilo #(
  parameter int ITER = 32
) (
  input  logic       clk,
  input  logic       rst,
  mdu_hilo_if.slave  bus
);

  localparam int CNT_W = $clog2(ITER);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             is_div_reg;
  logic             neg_a_reg;
  logic             neg_b_reg;
  logic             div_zero_reg;
  // Shared datapath: multiply uses {work_hi, work_lo} as the 64-bit
  // accumulator with the multiplier shifting out of work_lo; divide uses
  // work_hi as the partial remainder and work_lo as dividend/quotient.
  logic [31:0]      work_hi_reg;
  logic [31:0]      work_lo_reg;
  logic [31:0]      opnd_reg;     // multiplicand or divisor magnitude
  logic [31:0]      hi_reg;
  logic [31:0]      lo_reg;

  // Operand conditioning at acceptance
  logic        signed_op;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        skip;

  assign signed_op = ~bus.op[0];
  assign abs_a = (signed_op && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
  assign abs_b = (signed_op && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

`ifdef MDU_ZERO_SKIP_EN
  assign skip = bus.op[1] ? (bus.b == 32'd0)
                          : ((bus.a == 32'd0) || (bus.b == 32'd0));
`else
  assign skip = 1'b0;
`endif

  // Multiply step: conditional add into the upper half, then shift the
  // 65-bit {carry, hi, lo} right by one.
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, work_hi_reg} +
                   (work_lo_reg[0] ? {1'b0, opnd_reg} : 33'd0);

  // Restoring divide step. The partial remainder is always below the
  // divisor, so the shifted value fits in 33 bits and a successful
  // subtraction always fits back in 32.
  logic [32:0] div_shift;
  logic        div_ok;
  logic [31:0] div_diff;
  assign div_shift = {work_hi_reg, work_lo_reg[31]};
  assign div_ok    = (div_shift >= {1'b0, opnd_reg});
  assign div_diff  = div_shift[31:0] - opnd_reg;

  // Sign correction applied at FIN
  logic [63:0] prod_raw;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  assign prod_raw = {work_hi_reg, work_lo_reg};
  assign prod_fix = (neg_a_reg ^ neg_b_reg) ? (~prod_raw + 64'd1) : prod_raw;
  // With a zero divisor the restoring loop leaves rem = |a|, which the
  // dividend-sign correction turns back into the original a; only the
  // quotient needs forcing to all ones.
  assign quo_fix  = div_zero_reg ? 32'hFFFF_FFFF :
                    ((neg_a_reg ^ neg_b_reg) ? (~work_lo_reg + 32'd1) : work_lo_reg);
  assign rem_fix  = neg_a_reg ? (~work_hi_reg + 32'd1) : work_hi_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      is_div_reg   <= 1'b0;
      neg_a_reg    <= 1'b0;
      neg_b_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      work_hi_reg  <= '0;
      work_lo_reg  <= '0;
      opnd_reg     <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                is_div_reg   <= bus.op[1];
                neg_a_reg    <= signed_op & bus.a[31];
                neg_b_reg    <= signed_op & bus.b[31];
                div_zero_reg <= bus.op[1] & (bus.b == 32'd0);
                cnt_reg      <= '0;
                if (bus.op[1]) begin
                  opnd_reg    <= abs_b;
                  // Skipped divide (zero divisor): preload the values the
                  // loop would have produced.
                  work_hi_reg <= skip ? abs_a : 32'd0;
                  work_lo_reg <= skip ? 32'hFFFF_FFFF : abs_a;
                end else begin
                  opnd_reg    <= abs_a;
                  work_hi_reg <= 32'd0;
                  work_lo_reg <= skip ? 32'd0 : abs_b;
                end
                state_reg <= skip ? S_FIN : S_RUN;
              end
              3'd4:    hi_reg <= bus.a;
              3'd5:    lo_reg <= bus.a;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (is_div_reg) begin
            work_hi_reg <= div_ok ? div_diff : div_shift[31:0];
            work_lo_reg <= {work_lo_reg[30:0], div_ok};
          end else begin
            work_hi_reg <= mul_sum[32:1];
            work_lo_reg <= {mul_sum[0], work_lo_reg[31:1]};
          end
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(ITER - 1)) begin
            state_reg <= S_FIN;
          end
        end
        S_FIN: begin
          if (is_div_reg) begin
            hi_reg <= rem_fix;
            lo_reg <= quo_fix;
          end else begin
            hi_reg <= prod_fix[63:32];
            lo_reg <= prod_fix[31:0];
          end
          state_reg <= S_DONE;
        end
        default: begin
          // DONE: start is ignored so the held instruction cannot retrigger
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;
  assign bus.busy  = (state_reg != S_IDLE);
  assign bus.done  = (state_reg == S_DONE);
  assign bus.stall = ((state_reg == S_IDLE) && bus.start && !bus.op[2]) ||
                     (state_reg == S_RUN) || (state_reg == S_FIN);

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Iterative multiply/divide unit with the HI/LO register pair for the 54-instruction single-cycle CPU. It sits beside the ALU in the execute path and takes the same rs/rt operand buses. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Its `hi`/`lo` outputs feed the write-back result mux for MFHI/MFLO. While an operation runs, `stall` freezes the PC and register-file writes.

## Interface
- `ITER`, default 32: iterations per operation. Fixed at the data width; not to be overridden.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: decoder asserts while the current instruction is an MDU op.
- `op` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 reserved (no effect).
- `a` in 32 (`RegBus`): rs value, dividend/multiplicand/MT source.
- `b` in 32 (`RegBus`): rt value, divisor/multiplier.
- `hi` out 32: HI register.
- `lo` out 32: LO register.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: high for exactly one cycle, in state DONE.
- `stall` out 1: combinational; `(state==IDLE && start && op<=3) || state==RUN || state==FIN`.

## Operation
- FSM states:
  - IDLE: waits for an op.
  - RUN: one iteration per cycle; 5-bit counter.
  - FIN: sign correction, HI/LO write.
  - DONE: release cycle.
- IDLE with `start`:
  - op 0–3: latch op, |a|/|b| (or raw values for unsigned ops), and sign flags; counter ← 0; → RUN.
  - op 4: `hi`←`a` at the edge; stays IDLE; no stall.
  - op 5: `lo`←`a` at the edge; stays IDLE; no stall.
  - op 6–7: ignored.
- RUN:
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: radix-2 restoring, 33-bit partial remainder.
  - Counter increments each cycle; at counter==31 → FIN.
- FIN → DONE. At this edge:
  - Multiply: {hi,lo} ← product, negated (two's complement, 64-bit) if signed op and operand signs differ.
  - Divide: lo ← quotient, negated if signed and signs differ; hi ← remainder, negated if signed and dividend negative.
- DONE → IDLE unconditionally. `start` is ignored in DONE, so the still-held instruction cannot retrigger.
- `start`/`op`/`a`/`b` changes during RUN/FIN/DONE are ignored; operands were captured at entry.
- Divide by zero (DIV or DIVU): lo = 0xFFFFFFFF, hi = a (original, unsigned view).
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- `rst` at any time, including mid-operation: state→IDLE, counter=0, hi=lo=0, busy=done=0, operation discarded; stall drops to 0 immediately (unless IDLE with start).

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0. `stall` is 0 while `start` is low.
- Op 0–3 accepted at edge k:
  - RUN during cycles k..k+31 (edges k+1..k+32).
  - FIN after edge k+32.
  - HI/LO updated at edge k+33.
  - DONE in the cycle after k+33: done=1, stall=0, PC advances at edge k+34.
- `stall` high for 34 consecutive cycles per mult/div instruction: the request cycle, 32 RUN cycles, and FIN.
- MTHI/MTLO: zero stall; new value visible on `hi`/`lo` the cycle after the edge.
- Back-to-back mult/div: the next op is accepted no earlier than the first IDLE cycle after DONE.
- MFHI in the DONE cycle reads the new value.

## Configuration
- `MDU_ZERO_SKIP_EN`:
  - Defined: on acceptance, if a MULT/MULTU operand is zero, or a DIV/DIVU divisor is zero, IDLE → FIN directly, skipping RUN. Results are as specified above (product 0; divide-by-zero values). Stall is 2 cycles.
  - Undefined: every mult/div op runs the full 32 iterations; results are identical.

## Test plan
- MULT a=0xFFFFFFFE (-2), b=3 -> after 34 stall cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses exactly one cycle.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7 (with `MDU_ZERO_SKIP_EN`: stall 2 cycles).
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 in consecutive cycles -> no stall; hi/lo hold those values; a MULT with `start` held through DONE does not restart.
- Assert `rst` at RUN counter 15 of a DIV -> same cycle: busy=0, stall=0 (start low), hi=lo=0; a following MULTU 5×6 -> lo=30, hi=0.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
